// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the MEM-stage store path: size encodings,
// byte-enable constants and the lane-narrowed data record.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } st_size_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;

    // Lane-narrowed payload; the address width is a per-instance parameter,
    // so the full {addr, wdata, be} entry is declared in the top level
    // around this record.
    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_lane_t;

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request/memory/error bundle for store_narrow_unit.
// slave: the store unit itself; master: the pipeline + memory environment.
interface store_narrow_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              err_valid;
    logic [ADDR_W-1:0] err_addr;

    modport slave (
        input  in_valid, st_addr, st_data, st_size, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, mem_be,
        output err_valid, err_addr
    );

    modport master (
        output in_valid, st_addr, st_data, st_size, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, mem_be,
        input  err_valid, err_addr
    );
endinterface

// File: rtl/store_narrow_unit_lane_map.sv
// Combinational lane mapper: byte/half/word store data to replicated
// write data plus byte enables, with a misalignment flag.
module store_lane_map
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);
    logic [1:0] lane;

    // Select byte lanes and replicate data; misaligned halves/words fall
    // onto their naturally aligned lanes (addr[0] / addr[1:0] ignored).
    always_comb begin
        be         = BE_NONE;
        wdata      = data;
        misaligned = 1'b0;
        lane       = BIG_ENDIAN ? (2'd3 - addr_lo) : addr_lo;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{data[7:0]}};
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                be         = (addr_lo[1] ^ BIG_ENDIAN) ? BE_HI_HALF : BE_LO_HALF;
                wdata      = {2{data[15:0]}};
            end
            SZ_WORD: begin
                misaligned = |addr_lo;
                be         = BE_ALL;
            end
            default: begin
                be = BE_NONE;
            end
        endcase
    end
endmodule

// File: rtl/store_narrow_unit.sv
// MEM-stage store narrowing unit: output register + one-entry skid buffer
// between the EX/MEM register and the data-memory write port.
// Optional build macro STORE_MISALIGN_TRAP_EN: misaligned stores are
// accepted, dropped and reported on err_valid/err_addr; when undefined
// they are force-aligned and issued.
module store_narrow_unit
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    store_narrow_unit_if.slave  bus
);
`ifdef STORE_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        store_lane_t       lane;
    } entry_t;

    entry_t            new_e;
    entry_t            out_q;
    entry_t            skid_q;
    logic              out_valid;
    logic              skid_full;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [3:0]  map_be;
    logic [31:0] map_wdata;
    logic        map_mis;

    logic accept;
    logic reject;
    logic take;
    logic drain;
    logic out_free;

    store_lane_map #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_map (
        .addr_lo    (bus.st_addr[1:0]),
        .size       (bus.st_size),
        .data       (bus.st_data),
        .be         (map_be),
        .wdata      (map_wdata),
        .misaligned (map_mis)
    );

    // Handshake decode and formation of the narrowed entry.
    always_comb begin
        accept          = bus.in_valid && !skid_full;
        reject          = (bus.st_size == SZ_RSVD) || (TRAP_MISALIGN && map_mis);
        take            = accept && !reject;
        drain           = out_valid && bus.mem_ready;
        out_free        = !out_valid || drain;
        new_e.addr      = {bus.st_addr[ADDR_W-1:2], 2'b00};
        new_e.lane.wdata = map_wdata;
        new_e.lane.be    = map_be;
    end

    // Output register, skid buffer and error capture.
    // in_ready is !skid_full, so while the skid holds an entry no new store
    // can arrive and the skid always refills the output first (FIFO order).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_q      <= '0;
            skid_full  <= 1'b0;
            skid_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q <= accept && reject;
            if (accept && reject) begin
                err_addr_q <= bus.st_addr;
            end
            if (out_free) begin
                if (skid_full) begin
                    out_q     <= skid_q;
                    out_valid <= 1'b1;
                    skid_full <= 1'b0;
                end else if (take) begin
                    out_q     <= new_e;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (take) begin
                skid_q    <= new_e;
                skid_full <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = !skid_full;
    assign bus.mem_valid = out_valid;
    assign bus.mem_addr  = out_q.addr;
    assign bus.mem_wdata = out_q.lane.wdata;
    assign bus.mem_be    = out_q.lane.be;
    assign bus.err_valid = err_q;
    assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit. Two instances share stimulus:
// one little-endian, one big-endian. Honours STORE_MISALIGN_TRAP_EN.
module tb_store_narrow_unit;
    import store_pkg::*;

    localparam int unsigned AW = 32;
`ifdef STORE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_narrow_unit_if #(.ADDR_W(AW)) bus_le ();
    store_narrow_unit_if #(.ADDR_W(AW)) bus_be ();

    assign bus_be.in_valid  = bus_le.in_valid;
    assign bus_be.st_addr   = bus_le.st_addr;
    assign bus_be.st_data   = bus_le.st_data;
    assign bus_be.st_size   = bus_le.st_size;
    assign bus_be.mem_ready = bus_le.mem_ready;

    store_narrow_unit #(.ADDR_W(AW), .BIG_ENDIAN(1'b0)) dut_le (
        .clk (clk), .rst_n (rst_n), .bus (bus_le.slave));
    store_narrow_unit #(.ADDR_W(AW), .BIG_ENDIAN(1'b1)) dut_be (
        .clk (clk), .rst_n (rst_n), .bus (bus_be.slave));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be_le;
        logic [3:0]  be_be;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       obs_q[$];
    logic [31:0] exp_err[$];
    logic [31:0] obs_err[$];
    int checks = 0;
    int errors = 0;

    // Reference: expected effect of one accepted store, from the lane rules.
    function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                  input logic [31:0] data);
        beat_t b;
        int unsigned lane;
        bit mis;
        lane = addr % 4;
        mis  = (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && lane != 0);
        if (size == 2'd3 || (TRAP && mis)) begin
            exp_err.push_back(addr);
            return;
        end
        b.addr = addr - lane;
        if (size == 2'd0) begin
            b.be_le = 4'(1 << lane);
            b.be_be = 4'(1 << (3 - lane));
            b.wdata = 32'(data[7:0]) * 32'h0101_0101;
        end else if (size == 2'd1) begin
            b.be_le = (lane >= 2) ? 4'd12 : 4'd3;
            b.be_be = (lane >= 2) ? 4'd3 : 4'd12;
            b.wdata = 32'(data[15:0]) * 32'h0001_0001;
        end else begin
            b.be_le = 4'd15;
            b.be_be = 4'd15;
            b.wdata = data;
        end
        exp_q.push_back(b);
    endfunction

    // One clock: feed the model with accepts, record beats and error pulses.
    task automatic step();
        beat_t b;
        if (!rst_n) begin
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
            while (exp_err.size() > obs_err.size()) void'(exp_err.pop_back());
        end else begin
            if (bus_le.in_valid && bus_le.in_ready)
                model(bus_le.st_addr, bus_le.st_size, bus_le.st_data);
            if (bus_le.mem_valid && bus_le.mem_ready) begin
                b.addr  = bus_le.mem_addr;
                b.wdata = bus_le.mem_wdata;
                b.be_le = bus_le.mem_be;
                b.be_be = bus_be.mem_be;
                obs_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        if (bus_le.err_valid) obs_err.push_back(bus_le.err_addr);
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [1:0] s,
                           input logic [31:0] d);
        bus_le.in_valid = v;
        bus_le.st_addr  = a;
        bus_le.st_size  = s;
        bus_le.st_data  = d;
    endtask

    task automatic test_reset();
        set_req(1'b1, 32'h1234, 2'd2, 32'hFFFF_FFFF);
        bus_le.mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (bus_le.mem_valid !== 1'b0 || bus_le.mem_addr !== 32'h0 || bus_le.mem_wdata !== 32'h0 ||
            bus_le.mem_be !== 4'h0 || bus_le.err_valid !== 1'b0 || bus_le.err_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b addr=%h wdata=%h be=%b err=%b eaddr=%h, required all zero",
                     bus_le.mem_valid, bus_le.mem_addr, bus_le.mem_wdata, bus_le.mem_be,
                     bus_le.err_valid, bus_le.err_addr);
        end
        checks++;
        if (bus_le.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus_le.in_ready);
        end
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        rst_n = 1'b1;
        step();
        checks++;
        if (bus_le.in_ready !== 1'b1 || bus_le.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: in_ready=%b mem_valid=%b required 1/0",
                     bus_le.in_ready, bus_le.mem_valid);
        end
    endtask

    task automatic test_lane_map();
        bus_le.mem_ready = 1'b1;
        set_req(1'b1, 32'h1003, 2'd0, 32'hAABB_CCDD);
        step();
        checks++;
        if (bus_le.mem_valid !== 1'b1 || bus_le.mem_addr !== 32'h1000 || bus_le.mem_be !== 4'b1000 ||
            bus_le.mem_wdata !== 32'hDDDD_DDDD || bus_be.mem_be !== 4'b0001) begin
            errors++;
            $display("FAIL byte_store: v=%b addr=%h be=%b wdata=%h be_BE=%b required 1 1000 1000 dddddddd 0001",
                     bus_le.mem_valid, bus_le.mem_addr, bus_le.mem_be, bus_le.mem_wdata, bus_be.mem_be);
        end
        set_req(1'b1, 32'h2002, 2'd1, 32'h1234_ABCD);
        step();
        checks++;
        if (bus_le.mem_valid !== 1'b1 || bus_le.mem_addr !== 32'h2000 || bus_le.mem_be !== 4'b1100 ||
            bus_le.mem_wdata !== 32'hABCD_ABCD || bus_be.mem_be !== 4'b0011) begin
            errors++;
            $display("FAIL half_store: v=%b addr=%h be=%b wdata=%h be_BE=%b required 1 2000 1100 abcdabcd 0011",
                     bus_le.mem_valid, bus_le.mem_addr, bus_le.mem_be, bus_le.mem_wdata, bus_be.mem_be);
        end
        set_req(1'b1, 32'h2004, 2'd2, 32'h1234_ABCD);
        step();
        checks++;
        if (bus_le.mem_valid !== 1'b1 || bus_le.mem_addr !== 32'h2004 || bus_le.mem_be !== 4'b1111 ||
            bus_le.mem_wdata !== 32'h1234_ABCD) begin
            errors++;
            $display("FAIL word_store: v=%b addr=%h be=%b wdata=%h required 1 2004 1111 1234abcd",
                     bus_le.mem_valid, bus_le.mem_addr, bus_le.mem_be, bus_le.mem_wdata);
        end
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        step();
        checks++;
        if (bus_le.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL lane_idle: mem_valid=%b required 0", bus_le.mem_valid);
        end
    endtask

    task automatic test_back_pressure();
        bus_le.mem_ready = 1'b0;
        set_req(1'b1, 32'h0100, 2'd2, 32'h0A0B_0C0D);
        step();
        set_req(1'b1, 32'h0106, 2'd1, 32'h0000_5566);
        step();
        checks++;
        if (bus_le.in_ready !== 1'b0 || bus_le.mem_addr !== 32'h0100 || bus_le.mem_wdata !== 32'h0A0B_0C0D) begin
            errors++;
            $display("FAIL bp_skid_full: in_ready=%b addr=%h wdata=%h required 0 100 0a0b0c0d",
                     bus_le.in_ready, bus_le.mem_addr, bus_le.mem_wdata);
        end
        set_req(1'b1, 32'h010B, 2'd0, 32'h0000_0077);
        step();
        checks++;
        if (bus_le.in_ready !== 1'b0 || bus_le.mem_valid !== 1'b1 || bus_le.mem_addr !== 32'h0100 ||
            bus_le.mem_be !== 4'b1111) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b v=%b addr=%h be=%b required 0 1 100 1111",
                     bus_le.in_ready, bus_le.mem_valid, bus_le.mem_addr, bus_le.mem_be);
        end
        bus_le.mem_ready = 1'b1;
        step();
        checks++;
        if (bus_le.in_ready !== 1'b1 || bus_le.mem_addr !== 32'h0104 || bus_le.mem_be !== 4'b1100) begin
            errors++;
            $display("FAIL bp_skid_to_out: in_ready=%b addr=%h be=%b required 1 104 1100",
                     bus_le.in_ready, bus_le.mem_addr, bus_le.mem_be);
        end
        step();
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        checks++;
        if (bus_le.mem_addr !== 32'h0108 || bus_le.mem_be !== 4'b1000 || bus_le.mem_wdata !== 32'h7777_7777) begin
            errors++;
            $display("FAIL bp_third: addr=%h be=%b wdata=%h required 108 1000 77777777",
                     bus_le.mem_addr, bus_le.mem_be, bus_le.mem_wdata);
        end
        step();
    endtask

    task automatic test_misalign();
        bus_le.mem_ready = 1'b1;
        set_req(1'b1, 32'h3001, 2'd2, 32'hCAFE_F00D);
        step();
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        checks++;
        if (TRAP) begin
            if (bus_le.err_valid !== 1'b1 || bus_le.err_addr !== 32'h3001 || bus_le.mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_trap: err=%b eaddr=%h mem_valid=%b required 1 3001 0",
                         bus_le.err_valid, bus_le.err_addr, bus_le.mem_valid);
            end
        end else begin
            if (bus_le.mem_valid !== 1'b1 || bus_le.mem_addr !== 32'h3000 || bus_le.mem_be !== 4'b1111 ||
                bus_le.err_valid !== 1'b0) begin
                errors++;
                $display("FAIL misalign_force: v=%b addr=%h be=%b err=%b required 1 3000 1111 0",
                         bus_le.mem_valid, bus_le.mem_addr, bus_le.mem_be, bus_le.err_valid);
            end
        end
        step();
        checks++;
        if (bus_le.err_valid !== 1'b0 || bus_le.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after: err=%b mem_valid=%b required 0 0", bus_le.err_valid, bus_le.mem_valid);
        end
    endtask

    task automatic test_reserved();
        bus_le.mem_ready = 1'b1;
        set_req(1'b1, 32'h0040, 2'd3, 32'h1111_2222);
        step();
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        checks++;
        if (bus_le.err_valid !== 1'b1 || bus_le.err_addr !== 32'h0040 || bus_le.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reserved_pulse: err=%b eaddr=%h mem_valid=%b required 1 40 0",
                     bus_le.err_valid, bus_le.err_addr, bus_le.mem_valid);
        end
        step();
        step();
        checks++;
        if (bus_le.err_valid !== 1'b0 || bus_le.err_addr !== 32'h0040 || bus_le.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL reserved_hold: err=%b eaddr=%h mem_valid=%b required 0 40 0",
                     bus_le.err_valid, bus_le.err_addr, bus_le.mem_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic [3:0]  h_be;
        bit          stalled;
        bit          need_new = 1'b1;
        int unsigned r;
        for (int unsigned cyc = 0; cyc < 400; cyc++) begin
            if (need_new) begin
                r = $urandom_range(0, 9);
                set_req($urandom_range(0, 9) < 7, 32'h5000 + $urandom_range(0, 255),
                        (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3, $urandom);
            end
            bus_le.mem_ready = $urandom_range(0, 9) < 6;
            stalled = bus_le.mem_valid && !bus_le.mem_ready;
            h_addr  = bus_le.mem_addr;
            h_wdata = bus_le.mem_wdata;
            h_be    = bus_le.mem_be;
            need_new = !bus_le.in_valid || bus_le.in_ready;
            step();
            if (stalled) begin
                checks++;
                if (bus_le.mem_valid !== 1'b1 || bus_le.mem_addr !== h_addr ||
                    bus_le.mem_wdata !== h_wdata || bus_le.mem_be !== h_be) begin
                    errors++;
                    $display("FAIL stall_stable: v=%b addr=%h wdata=%h be=%b required 1 %h %h %b",
                             bus_le.mem_valid, bus_le.mem_addr, bus_le.mem_wdata, bus_le.mem_be,
                             h_addr, h_wdata, h_be);
                end
            end
        end
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        bus_le.mem_ready = 1'b1;
        for (int unsigned i = 0; i < 10 && bus_le.mem_valid; i++) step();
        step();
        checks++;
        if (bus_le.mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: mem_valid=%b required 0 within budget", bus_le.mem_valid);
        end
    endtask

    task automatic test_reset_flush();
        bus_le.mem_ready = 1'b0;
        set_req(1'b1, 32'h7000, 2'd2, 32'hDEAD_0001);
        step();
        set_req(1'b1, 32'h7004, 2'd2, 32'hDEAD_0002);
        step();
        checks++;
        if (bus_le.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup: in_ready=%b required 0", bus_le.in_ready);
        end
        rst_n = 1'b0;
        bus_le.mem_ready = 1'b1;
        step();
        checks++;
        if (bus_le.mem_valid !== 1'b0 || bus_le.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_reset: mem_valid=%b in_ready=%b required 0 1", bus_le.mem_valid, bus_le.in_ready);
        end
        rst_n = 1'b1;
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        for (int unsigned i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus_le.mem_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost: mem_valid=%b addr=%h required 0", bus_le.mem_valid, bus_le.mem_addr);
            end
        end
    endtask

    task automatic test_scoreboard();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL beat_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int unsigned i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].wdata !== exp_q[i].wdata ||
                obs_q[i].be_le !== exp_q[i].be_le || obs_q[i].be_be !== exp_q[i].be_be) begin
                errors++;
                $display("FAIL beat[%0d]: got %h/%h/%b/%b required %h/%h/%b/%b", i,
                         obs_q[i].addr, obs_q[i].wdata, obs_q[i].be_le, obs_q[i].be_be,
                         exp_q[i].addr, exp_q[i].wdata, exp_q[i].be_le, exp_q[i].be_be);
            end
        end
        checks++;
        if (obs_err.size() != exp_err.size()) begin
            errors++;
            $display("FAIL err_count: got %0d required %0d", obs_err.size(), exp_err.size());
        end
        for (int unsigned i = 0; i < obs_err.size() && i < exp_err.size(); i++) begin
            checks++;
            if (obs_err[i] !== exp_err[i]) begin
                errors++;
                $display("FAIL err[%0d]: got %h required %h", i, obs_err[i], exp_err[i]);
            end
        end
    endtask

    initial begin
        set_req(1'b0, 32'h0, 2'd0, 32'h0);
        bus_le.mem_ready = 1'b0;
        test_reset();
        test_lane_map();
        test_back_pressure();
        test_misalign();
        test_reserved();
        test_random();
        test_reset_flush();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
